// File: rtl/stq_commit_buffer.sv
// -----------------------------------------------------------------------------
// stq_commit_buffer
//
// In-order store queue between dispatch, the AGU writeback port, ROB commit
// and the data-cache write port. Stores enter in program order at the tail and
// leave at the head once committed.
//
// Each entry moves through these states:
//   FREE -> WAIT (dispatched) -> RES (address/data known) -> CMT (committed)
//   CMT -> FREE when the cache accepts the drain.
//
// Loads query the queue combinationally for forwarding from older stores.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   flush                drop every uncommitted (WAIT/RES) entry
//   disp_valid/tag/rdy   dispatch of up to DISP_W stores per cycle, packed
//                        from slot 0
//   agu_*                address/data/size resolution for one ROB tag
//   commit_valid/tag     ROB store-commit strobes
//   rob_head             oldest in-flight ROB tag, used to order loads
//                        against stores
//   mem_req_*            head-entry drain toward the cache (valid/ready)
//   ld_*, fwd_*          load forwarding query and result
//   count                occupied entries
// -----------------------------------------------------------------------------
module stq_commit_buffer #(
   parameter int DEPTH     = 8,
   parameter int DISP_W    = 2,
   parameter int COMMIT_W  = 2,
   parameter int TAG_WIDTH = 6,
   parameter int ADDR_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [DISP_W-1:0]             disp_valid,
   input  logic [DISP_W*TAG_WIDTH-1:0]   disp_tag,
   output logic [DISP_W-1:0]             disp_rdy,
   input  logic                          agu_valid,
   input  logic [TAG_WIDTH-1:0]          agu_tag,
   input  logic [ADDR_W-1:0]             agu_addr,
   input  logic [31:0]                   agu_data,
   input  logic [1:0]                    agu_size,
   input  logic [COMMIT_W-1:0]           commit_valid,
   input  logic [COMMIT_W*TAG_WIDTH-1:0] commit_tag,
   input  logic [TAG_WIDTH-1:0]          rob_head,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic [ADDR_W-1:0]             mem_req_addr,
   output logic [31:0]                   mem_req_data,
   output logic [3:0]                    mem_req_mask,
   input  logic                          ld_query_valid,
   input  logic [TAG_WIDTH-1:0]          ld_tag,
   input  logic [ADDR_W-1:0]             ld_addr,
   input  logic [1:0]                    ld_size,
   output logic                          fwd_hit,
   output logic [31:0]                   fwd_data,
   output logic                          fwd_wait,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RES  = 2'd2,
      ST_CMT  = 2'd3
   } ent_st_e;

   // Control state (reset)
   ent_st_e           st_q [DEPTH];
   ent_st_e           st_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Payload state (not reset; only meaningful while the entry is not FREE)
   logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
   logic [TAG_WIDTH-1:0] tag_d  [DEPTH];
   logic [WA_W-1:0]      wa_q   [DEPTH];
   logic [WA_W-1:0]      wa_d   [DEPTH];
   logic [31:0]          data_q [DEPTH];
   logic [31:0]          data_d [DEPTH];
   logic [3:0]           mask_q [DEPTH];
   logic [3:0]           mask_d [DEPTH];

   logic                 drain;
   logic [CNT_W-1:0]     n_disp;
   logic [CNT_W-1:0]     n_cmt;
   logic [PTR_W-1:0]     disp_idx;
   logic [3:0]           agu_mask;
   logic [31:0]          agu_lane_data;

   // Byte-enable pattern for an access size, before lane alignment.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Expand a byte mask into a 32-bit bit mask.
   function automatic logic [31:0] byte_bits(input logic [3:0] m);
      logic [31:0] b;
      for (int k = 0; k < 4; k++) begin
         b[8*k +: 8] = {8{m[k]}};
      end
      return b;
   endfunction

   function automatic logic tag_committed(
      input logic [TAG_WIDTH-1:0]          t,
      input logic [COMMIT_W-1:0]           cv,
      input logic [COMMIT_W*TAG_WIDTH-1:0] ct
   );
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < COMMIT_W; c++) begin
         if (cv[c] && (ct[c*TAG_WIDTH +: TAG_WIDTH] == t)) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   // AGU payload is masked to its size, then moved to its byte lanes so the
   // stored word is exactly what the cache write needs.
   assign agu_mask      = size_mask(agu_size) << agu_addr[1:0];
   assign agu_lane_data = (agu_data & byte_bits(size_mask(agu_size)))
                          << {agu_addr[1:0], 3'b000};

   // Drain port: the head entry is presented as soon as it is committed.
   assign mem_req_valid = (st_q[head_q] == ST_CMT);
   assign mem_req_addr  = {wa_q[head_q], 2'b00};
   assign mem_req_data  = data_q[head_q];
   assign mem_req_mask  = mask_q[head_q];
   assign drain         = mem_req_valid && mem_req_ready;

   // Dispatch readiness uses the registered count only, so a same-cycle
   // drain never opens a dispatch slot.
   always_comb begin
      for (int i = 0; i < DISP_W; i++) begin
         disp_rdy[i] = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(i + 1));
      end
   end

   assign count = count_q;

   // Next-state: AGU write, then commit, then drain, then flush or dispatch.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         st_d[i]   = st_q[i];
         tag_d[i]  = tag_q[i];
         wa_d[i]   = wa_q[i];
         data_d[i] = data_q[i];
         mask_d[i] = mask_q[i];
      end
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      n_disp   = '0;
      n_cmt    = '0;
      disp_idx = tail_q;

      for (int i = 0; i < DEPTH; i++) begin
         // A flush in the same cycle discards the AGU write.
         if (agu_valid && !flush && (st_q[i] == ST_WAIT) && (tag_q[i] == agu_tag)) begin
            st_d[i]   = ST_RES;
            wa_d[i]   = agu_addr[ADDR_W-1:2];
            data_d[i] = agu_lane_data;
            mask_d[i] = agu_mask;
         end
         // Checking st_d lets a same-cycle AGU write and commit reach CMT.
         if ((st_d[i] == ST_RES) && tag_committed(tag_q[i], commit_valid, commit_tag)) begin
            st_d[i] = ST_CMT;
         end
      end

      if (drain) begin
         st_d[head_q] = ST_FREE;
         head_d       = head_q + PTR_W'(1);
      end

      if (flush) begin
         // Committed entries are contiguous from the head, so the new tail
         // sits just past them.
         for (int i = 0; i < DEPTH; i++) begin
            if ((st_d[i] == ST_WAIT) || (st_d[i] == ST_RES)) begin
               st_d[i] = ST_FREE;
            end
            if (st_d[i] == ST_CMT) begin
               n_cmt = n_cmt + CNT_W'(1);
            end
         end
         tail_d  = head_d + n_cmt[PTR_W-1:0];
         count_d = n_cmt;
      end else begin
         for (int d = 0; d < DISP_W; d++) begin
            if (disp_valid[d]) begin
               disp_idx          = tail_q + PTR_W'(d);
               st_d[disp_idx]    = ST_WAIT;
               tag_d[disp_idx]   = disp_tag[d*TAG_WIDTH +: TAG_WIDTH];
               n_disp            = n_disp + CNT_W'(1);
            end
         end
         tail_d  = tail_q + n_disp[PTR_W-1:0];
         count_d = count_q + n_disp - CNT_W'(drain);
      end
   end

   // Forwarding lookup, scanned oldest to youngest so the last match wins.
   logic [PTR_W-1:0]     fw_idx;
   logic [PTR_W-1:0]     fw_sel;
   logic                 fw_found;
   logic                 fw_any_wait;
   logic                 fw_qual;
   logic [3:0]           fw_ld_mask;
   logic [TAG_WIDTH-1:0] fw_ld_rel;
   logic [TAG_WIDTH-1:0] fw_ent_rel;

   always_comb begin
      fwd_hit     = 1'b0;
      fwd_wait    = 1'b0;
      fwd_data    = '0;
      fw_found    = 1'b0;
      fw_any_wait = 1'b0;
      fw_sel      = head_q;
      fw_idx      = head_q;
      fw_qual     = 1'b0;
      fw_ent_rel  = '0;
      fw_ld_mask  = size_mask(ld_size) << ld_addr[1:0];
      // Age relative to the ROB head, so tag wrap-around orders correctly.
      fw_ld_rel   = ld_tag - rob_head;

      for (int o = 0; o < DEPTH; o++) begin
         fw_idx     = head_q + PTR_W'(o);
         fw_ent_rel = tag_q[fw_idx] - rob_head;
         fw_qual    = (st_q[fw_idx] != ST_FREE) &&
                      ((st_q[fw_idx] == ST_CMT) || (fw_ent_rel < fw_ld_rel));
         if (fw_qual && (st_q[fw_idx] == ST_WAIT)) begin
            fw_any_wait = 1'b1;
         end
         if (fw_qual && (st_q[fw_idx] != ST_WAIT) &&
             (wa_q[fw_idx] == ld_addr[ADDR_W-1:2]) &&
             ((mask_q[fw_idx] & fw_ld_mask) != 4'b0000)) begin
            fw_found = 1'b1;
            fw_sel   = fw_idx;
         end
      end

      if (ld_query_valid) begin
         if (fw_any_wait) begin
            fwd_wait = 1'b1;
         end else if (fw_found) begin
            if ((mask_q[fw_sel] & fw_ld_mask) == fw_ld_mask) begin
               fwd_hit  = 1'b1;
               fwd_data = (data_q[fw_sel] >> {ld_addr[1:0], 3'b000})
                          & byte_bits(size_mask(ld_size));
            end else begin
               fwd_wait = 1'b1;
            end
         end
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i] <= ST_FREE;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i] <= st_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload registers
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         tag_q[i]  <= tag_d[i];
         wa_q[i]   <= wa_d[i];
         data_q[i] <= data_d[i];
         mask_q[i] <= mask_d[i];
      end
   end

endmodule

// File: tb/tb_stq_commit_buffer.sv
module tb_stq_commit_buffer;

   localparam int DEPTH = 8;
   localparam int TW    = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  disp_valid;
   logic [11:0] disp_tag;
   logic [1:0]  disp_rdy;
   logic        agu_valid;
   logic [5:0]  agu_tag;
   logic [31:0] agu_addr;
   logic [31:0] agu_data;
   logic [1:0]  agu_size;
   logic [1:0]  commit_valid;
   logic [11:0] commit_tag;
   logic [5:0]  rob_head;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_mask;
   logic        ld_query_valid;
   logic [5:0]  ld_tag;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        fwd_wait;
   logic [3:0]  count;

   always #5 clk = ~clk;

   stq_commit_buffer #(
      .DEPTH(DEPTH), .DISP_W(2), .COMMIT_W(2), .TAG_WIDTH(TW), .ADDR_W(32)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_tag(disp_tag), .disp_rdy(disp_rdy),
      .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr),
      .agu_data(agu_data), .agu_size(agu_size),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .rob_head(rob_head),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_mask(mem_req_mask),
      .ld_query_valid(ld_query_valid), .ld_tag(ld_tag), .ld_addr(ld_addr),
      .ld_size(ld_size), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .fwd_wait(fwd_wait), .count(count)
   );

   // Reference model: program-ordered list of stores. st: 0 WAIT, 1 RES, 2 CMT.
   typedef struct {
      int          tag;
      int unsigned addr;
      int          sz;
      int unsigned data;
      int          st;
   } mst_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } req_t;

   mst_t ml[$];
   req_t exp_q[$];
   req_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [5:0] next_tag;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int rel(input int t);
      return (t - int'(rob_head)) & 63;
   endfunction

   // Cache write a committed store should produce, by byte arithmetic.
   function automatic req_t mk_req(input mst_t s);
      req_t r;
      int off, nb;
      off = int'(s.addr % 4);
      nb  = 1 << s.sz;
      r.addr = s.addr - off;
      r.mask = 4'(((1 << nb) - 1) << off);
      r.data = 0;
      for (int b = 0; b < nb; b++) begin
         r.data = r.data | (((s.data >> (8 * b)) & 32'hFF) << (8 * (off + b)));
      end
      return r;
   endfunction

   task automatic model_fwd(output bit hit, output bit wt, output logic [31:0] d);
      int lo, nb, so, sn, y;
      bit anyw, qual;
      hit = 0; wt = 0; d = 0;
      if (!ld_query_valid) return;
      lo = int'(ld_addr % 4);
      nb = 1 << ld_size;
      anyw = 0; y = -1;
      for (int i = 0; i < ml.size(); i++) begin
         qual = (ml[i].st == 2) || (rel(ml[i].tag) < rel(int'(ld_tag)));
         if (qual && ml[i].st == 0) anyw = 1;
         if (qual && ml[i].st != 0 && (ml[i].addr / 4 == ld_addr / 4)) begin
            so = int'(ml[i].addr % 4);
            sn = 1 << ml[i].sz;
            if (so < lo + nb && lo < so + sn) y = i;
         end
      end
      if (anyw) wt = 1;
      else if (y >= 0) begin
         so = int'(ml[y].addr % 4);
         sn = 1 << ml[y].sz;
         if (so <= lo && so + sn >= lo + nb) begin
            hit = 1;
            for (int b = 0; b < nb; b++)
               d = d | (((ml[y].data >> (8 * (lo + b - so))) & 32'hFF) << (8 * b));
         end else wt = 1;
      end
   endtask

   task automatic model_edge();
      bit dr;
      mst_t keep[$];
      dr = mem_req_ready && ml.size() > 0 && ml[0].st == 2;
      if (agu_valid && !flush)
         for (int i = 0; i < ml.size(); i++)
            if (ml[i].st == 0 && ml[i].tag == int'(agu_tag)) begin
               ml[i].st = 1; ml[i].addr = agu_addr; ml[i].sz = int'(agu_size); ml[i].data = agu_data;
            end
      for (int i = 0; i < ml.size(); i++)
         if (ml[i].st == 1 && ((commit_valid[0] && int'(commit_tag[5:0]) == ml[i].tag) ||
                               (commit_valid[1] && int'(commit_tag[11:6]) == ml[i].tag))) begin
            ml[i].st = 2;
            exp_q.push_back(mk_req(ml[i]));
         end
      if (dr) void'(ml.pop_front());
      if (flush) begin
         foreach (ml[i]) if (ml[i].st == 2) keep.push_back(ml[i]);
         ml = keep;
      end else begin
         for (int d = 0; d < 2; d++)
            if (disp_valid[d]) begin
               mst_t n;
               n.tag = int'(disp_tag[6*d +: 6]); n.addr = 0; n.sz = 0; n.data = 0; n.st = 0;
               ml.push_back(n);
            end
      end
   endtask

   function automatic logic [1:0] exp_rdy();
      logic [1:0] r;
      for (int i = 0; i < 2; i++) r[i] = (DEPTH - ml.size()) >= i + 1;
      return r;
   endfunction

   task automatic cycle();
      bit eh, ew;
      logic [31:0] ed;
      #1;
      model_fwd(eh, ew, ed);
      chk("fwd_hit", 32'(fwd_hit), 32'(eh));
      chk("fwd_wait", 32'(fwd_wait), 32'(ew));
      chk("fwd_data", fwd_data, ed);
      @(posedge clk);
      model_edge();
      #1;
      disp_valid = '0; agu_valid = 0; commit_valid = '0; flush = 0;
      chk("count", 32'(count), 32'(ml.size()));
      chk("disp_rdy", 32'(disp_rdy), 32'(exp_rdy()));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(ml.size() > 0 && ml[0].st == 2));
   endtask

   function automatic logic [31:0] rand_addr(input logic [1:0] sz);
      logic [31:0] a;
      a = 32'h400 + 32'($urandom_range(0, 15));
      if (sz == 2) a = a & ~32'h3;
      else if (sz == 1) a = a & ~32'h1;
      return a;
   endfunction

   task automatic randq();
      rob_head = next_tag;
      for (int i = ml.size() - 1; i >= 0; i--) if (ml[i].st != 2) rob_head = 6'(ml[i].tag);
      ld_query_valid = 1'($urandom_range(0, 1));
      ld_tag  = rob_head + 6'($urandom_range(0, 8));
      ld_size = 2'($urandom_range(0, 2));
      ld_addr = rand_addr(ld_size);
   endtask

   task automatic drive_agu(input logic [5:0] t);
      agu_valid = 1;
      agu_tag   = t;
      agu_size  = 2'($urandom_range(0, 2));
      agu_addr  = rand_addr(agu_size);
      agu_data  = $urandom();
   endtask

   // Drain monitor: every accepted cache write is compared with the oldest
   // expected one.
   always @(negedge clk) begin
      if (rst && mem_req_valid && mem_req_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_unexpected: got addr 0x%08h, want no drain", mem_req_addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("drain_addr", mem_req_addr, mon_e.addr);
            chk("drain_data", mem_req_data, mon_e.data);
            chk("drain_mask", 32'(mem_req_mask), 32'(mon_e.mask));
         end
      end
   end

   initial begin
      rst = 0; flush = 0; disp_valid = '0; disp_tag = '0;
      agu_valid = 0; agu_tag = '0; agu_addr = '0; agu_data = '0; agu_size = '0;
      commit_valid = '0; commit_tag = '0; rob_head = '0; mem_req_ready = 0;
      ld_query_valid = 1; ld_tag = 6'd5; ld_addr = '0; ld_size = 2'd2;
      #12;
      chk("rst_count", 32'(count), 0);
      chk("rst_disp_rdy", 32'(disp_rdy), 32'h3);
      chk("rst_mem_valid", 32'(mem_req_valid), 0);
      chk("rst_fwd_hit", 32'(fwd_hit), 0);
      chk("rst_fwd_wait", 32'(fwd_wait), 0);
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      ld_query_valid = 0;

      // Two stores in one cycle
      disp_valid = 2'b11; disp_tag = {6'd4, 6'd3}; cycle();
      chk("tp1_count", 32'(count), 2);
      chk("tp1_rdy", 32'(disp_rdy), 32'h3);

      // AGU and commit in one cycle, drain visible after the commit edge
      mem_req_ready = 1;
      agu_valid = 1; agu_tag = 6'd3; agu_addr = 32'h102; agu_size = 2'd1; agu_data = 32'h0000BEEF;
      commit_valid = 2'b01; commit_tag = {6'd0, 6'd3};
      cycle();
      chk("tp2_valid", 32'(mem_req_valid), 1);
      chk("tp2_addr", mem_req_addr, 32'h100);
      chk("tp2_mask", 32'(mem_req_mask), 32'hC);
      chk("tp2_data", mem_req_data, 32'hBEEF0000);
      cycle();
      agu_valid = 1; agu_tag = 6'd4; agu_addr = 32'h300; agu_size = 2'd2; agu_data = 32'hCAFEF00D;
      cycle();
      commit_valid = 2'b01; commit_tag = {6'd0, 6'd4}; cycle();
      cycle();

      // Forwarding: full cover hits, partial overlap waits
      disp_valid = 2'b11; disp_tag = {6'd6, 6'd5}; cycle();
      agu_valid = 1; agu_tag = 6'd5; agu_addr = 32'h200; agu_size = 2'd2; agu_data = 32'h11223344; cycle();
      agu_valid = 1; agu_tag = 6'd6; agu_addr = 32'h201; agu_size = 2'd0; agu_data = 32'h000000AA; cycle();
      rob_head = 6'd0; ld_query_valid = 1; ld_tag = 6'd7; ld_addr = 32'h201; ld_size = 2'd0;
      #1;
      chk("tp3_hit", 32'(fwd_hit), 1);
      chk("tp3_data", fwd_data, 32'hAA);
      ld_addr = 32'h200; ld_size = 2'd2;
      #1;
      chk("tp3_wait", 32'(fwd_wait), 1);
      chk("tp3_nohit", 32'(fwd_hit), 0);
      cycle();
      ld_query_valid = 0;
      commit_valid = 2'b11; commit_tag = {6'd6, 6'd5}; cycle();
      for (int i = 0; i < 4; i++) cycle();

      // Fill, commit two, flush with the cache stalled
      mem_req_ready = 0;
      for (int i = 0; i < 4; i++) begin
         disp_valid = 2'b11; disp_tag = {6'(9 + 2 * i), 6'(8 + 2 * i)}; cycle();
      end
      chk("tp4_full_rdy", 32'(disp_rdy), 0);
      chk("tp4_full_count", 32'(count), 8);
      agu_valid = 1; agu_tag = 6'd8; agu_addr = 32'h500; agu_size = 2'd2; agu_data = 32'h08080808; cycle();
      agu_valid = 1; agu_tag = 6'd9; agu_addr = 32'h504; agu_size = 2'd2; agu_data = 32'h09090909;
      commit_valid = 2'b01; commit_tag = {6'd0, 6'd8}; cycle();
      commit_valid = 2'b01; commit_tag = {6'd0, 6'd9}; cycle();
      flush = 1; cycle();
      chk("tp4_flush_count", 32'(count), 2);
      // New stores land right after the survivors and drain behind them
      disp_valid = 2'b11; disp_tag = {6'd17, 6'd16}; cycle();
      agu_valid = 1; agu_tag = 6'd16; agu_addr = 32'h600; agu_size = 2'd2; agu_data = 32'h16161616;
      commit_valid = 2'b01; commit_tag = {6'd0, 6'd16}; cycle();
      mem_req_ready = 1;
      for (int i = 0; i < 4; i++) cycle();
      chk("tp4_after_drain", 32'(count), 1);

      // Load older than the unresolved store: no wait; younger load: wait
      rob_head = 6'd0; ld_query_valid = 1; ld_tag = 6'd10; ld_addr = 32'h600; ld_size = 2'd2;
      #1;
      chk("tp5_old_hit", 32'(fwd_hit), 0);
      chk("tp5_old_wait", 32'(fwd_wait), 0);
      ld_tag = 6'd20;
      #1;
      chk("tp5_young_wait", 32'(fwd_wait), 1);
      ld_query_valid = 0;
      flush = 1; cycle();
      chk("tp5_flush_empty", 32'(count), 0);

      // Randomised rounds; pointers wrap several times
      next_tag = 6'd18;
      for (int r = 0; r < 20; r++) begin
         logic [5:0] t0, t1;
         for (int g = 0; g < 20 && ml.size() > DEPTH - 2; g++) begin
            mem_req_ready = 1; randq(); cycle();
         end
         t0 = next_tag; t1 = next_tag + 6'd1; next_tag = next_tag + 6'd2;
         mem_req_ready = ($urandom_range(0, 3) != 0);
         disp_valid = 2'b11; disp_tag = {t1, t0}; randq(); cycle();
         mem_req_ready = ($urandom_range(0, 3) != 0);
         drive_agu(t0); randq(); cycle();
         mem_req_ready = ($urandom_range(0, 3) != 0);
         drive_agu(t1); commit_valid = 2'b01; commit_tag = {6'd0, t0}; randq(); cycle();
         mem_req_ready = ($urandom_range(0, 3) != 0);
         commit_valid = 2'b01; commit_tag = {6'd0, t1}; randq(); cycle();
      end
      mem_req_ready = 1; ld_query_valid = 0;
      for (int g = 0; g < 30 && ml.size() > 0; g++) cycle();
      cycle();
      chk("final_count", 32'(count), 0);
      chk("final_drains_left", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
